// File: rtl/ram_rw_arbiter.sv
// Shared memory port arbiter between instruction fetch and load/store.
// Fair round-robin grant, registered memory request, timeout recovery.
module ram_rw_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_data_o,
  input  logic        ls_req_i,
  input  logic        ls_wen_i,
  input  logic [63:0] ls_addr_i,
  input  logic [63:0] ls_wdata_i,
  input  logic [7:0]  ls_wmask_i,
  input  logic [2:0]  ls_size_i,
  output logic        ls_ready_o,
  output logic [63:0] ls_rdata_o,
  output logic        ram_cen_o,
  output logic        ram_wen_o,
  output logic [63:0] ram_addr_o,
  output logic [63:0] ram_wdata_o,
  output logic [7:0]  ram_wmask_o,
  output logic [2:0]  ram_size_o,
  input  logic        ram_ready_i,
  input  logic [63:0] ram_data_i,
  output logic        err_o
);

  localparam int CLOG = $clog2(TIMEOUT);
  localparam int CW = (CLOG > 10) ? CLOG : 10;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_ls_q, last_ls_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        cen_q, cen_d;
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [2:0]  size_q, size_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_ready_q, ls_ready_d;
  logic [63:0] ls_rdata_q, ls_rdata_d;
  logic        err_q, err_d;
  logic        grant_ls;
  logic        expired;
  logic [63:0] rd;

  assign grant_ls = ls_req_i & (~if_req_i | ~last_ls_q);
  assign expired  = (cnt_q == CW'(TIMEOUT - 1));
  assign rd       = ram_ready_i ? ram_data_i : 64'd0;

  // Next-state: grant in IDLE, wait for memory in REQ, pulse in RESP.
  always_comb begin
    state_d    = state_q;
    last_ls_d  = last_ls_q;
    cnt_d      = cnt_q;
    cen_d      = cen_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    size_d     = size_q;
    if_ready_d = 1'b0;
    if_data_d  = if_data_q;
    ls_ready_d = 1'b0;
    ls_rdata_d = ls_rdata_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (if_req_i | ls_req_i) begin
          state_d   = REQ;
          cen_d     = 1'b1;
          cnt_d     = '0;
          last_ls_d = grant_ls;
          if (grant_ls) begin
            wen_d   = ls_wen_i;
            addr_d  = ls_addr_i;
            wdata_d = ls_wdata_i;
            wmask_d = ls_wmask_i;
            size_d  = ls_size_i;
          end else begin
            wen_d   = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = 64'd0;
            wmask_d = 8'd0;
            size_d  = 3'd2;
          end
        end
      end
      REQ: begin
        if (ram_ready_i | expired) begin
          state_d = RESP;
          cen_d   = 1'b0;
          err_d   = err_q | ~ram_ready_i;
          if (last_ls_q) begin
            ls_ready_d = 1'b1;
            ls_rdata_d = wen_q ? 64'd0 : rd;
          end else begin
            if_ready_d = 1'b1;
            if_data_d  = addr_q[2] ? rd[63:32] : rd[31:0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_ls_q  <= 1'b0;
      cnt_q      <= '0;
      cen_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      wmask_q    <= 8'd0;
      size_q     <= 3'd0;
      if_ready_q <= 1'b0;
      if_data_q  <= 32'd0;
      ls_ready_q <= 1'b0;
      ls_rdata_q <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ls_q  <= last_ls_d;
      cnt_q      <= cnt_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      size_q     <= size_d;
      if_ready_q <= if_ready_d;
      if_data_q  <= if_data_d;
      ls_ready_q <= ls_ready_d;
      ls_rdata_q <= ls_rdata_d;
      err_q      <= err_d;
    end
  end

  assign ram_cen_o   = cen_q;
  assign ram_wen_o   = wen_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign ram_wmask_o = wmask_q;
  assign ram_size_o  = size_q;
  assign if_ready_o  = if_ready_q;
  assign if_data_o   = if_data_q;
  assign ls_ready_o  = ls_ready_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Bench for ram_rw_arbiter: one-cycle memory model with stall and
// stale-ready injection, completions checked against a scoreboard.
module tb_ram_rw_arbiter;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_i = 1'b0;
  logic [63:0] if_addr_i = 64'd0;
  logic        if_ready_o;
  logic [31:0] if_data_o;
  logic        ls_req_i = 1'b0;
  logic        ls_wen_i = 1'b0;
  logic [63:0] ls_addr_i = 64'd0;
  logic [63:0] ls_wdata_i = 64'd0;
  logic [7:0]  ls_wmask_i = 8'd0;
  logic [2:0]  ls_size_i = 3'd0;
  logic        ls_ready_o;
  logic [63:0] ls_rdata_o;
  logic        ram_cen_o;
  logic        ram_wen_o;
  logic [63:0] ram_addr_o;
  logic [63:0] ram_wdata_o;
  logic [7:0]  ram_wmask_o;
  logic [2:0]  ram_size_o;
  logic        ram_ready_i;
  logic [63:0] ram_data_i;
  logic        err_o;

  logic        mem_en = 1'b1;
  logic        stale = 1'b0;
  logic        mem_ready;
  logic [63:0] mem_data = 64'h11223344_55667788;

  typedef struct packed {
    logic        is_ls;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_tests = 0;
  int n_fail = 0;

  ram_rw_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_data_o(if_data_o),
    .ls_req_i(ls_req_i), .ls_wen_i(ls_wen_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_wmask_i(ls_wmask_i), .ls_size_i(ls_size_i),
    .ls_ready_o(ls_ready_o), .ls_rdata_o(ls_rdata_o),
    .ram_cen_o(ram_cen_o), .ram_wen_o(ram_wen_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_wmask_o(ram_wmask_o), .ram_size_o(ram_size_o),
    .ram_ready_i(ram_ready_i), .ram_data_i(ram_data_i),
    .err_o(err_o)
  );

  always #5 clock = ~clock;

  assign ram_ready_i = mem_ready | stale;
  assign ram_data_i  = mem_data;

  always @(posedge clock) begin
    if (reset) mem_ready <= 1'b0;
    else mem_ready <= mem_en & ram_cen_o & ~mem_ready;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && (if_ready_o | ls_ready_o)) begin
      check("one_ready", 64'(if_ready_o & ls_ready_o), 64'd0);
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ready_port", 64'(ls_ready_o), 64'(e.is_ls));
        check("ready_data",
              ls_ready_o ? ls_rdata_o : {32'd0, if_data_o}, e.data);
      end
    end
  end

  task automatic wait_ready(input bit ls, input int exp_lat,
                            input logic [63:0] a, input logic [63:0] wd,
                            input logic w, input logic [7:0] m,
                            input logic [2:0] s);
    int lat = 0;
    bit seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clock);
      lat++;
      if (ram_cen_o) begin
        check("ram_addr", ram_addr_o, a);
        check("ram_wdata", ram_wdata_o, wd);
        check("ram_wen", 64'(ram_wen_o), 64'(w));
        check("ram_wmask", 64'(ram_wmask_o), 64'(m));
        check("ram_size", 64'(ram_size_o), 64'(s));
      end
      seen = ls ? ls_ready_o : if_ready_o;
    end
    check("ready_seen", 64'(seen), 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_cen", 64'(ram_cen_o), 64'd0);
  endtask

  task automatic do_xact(input bit ls, input logic w,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [7:0] m, input logic [2:0] s,
                         input logic [63:0] expd, input int lat);
    @(negedge clock);
    if (ls) begin
      ls_req_i = 1'b1;
      ls_wen_i = w;
      ls_addr_i = a;
      ls_wdata_i = wd;
      ls_wmask_i = m;
      ls_size_i = s;
    end else begin
      if_req_i = 1'b1;
      if_addr_i = a;
    end
    sb.push_back('{ls, expd});
    if (ls) wait_ready(1'b1, lat, a, wd, w, m, s);
    else wait_ready(1'b0, lat, a, 64'd0, 1'b0, 8'd0, 3'd2);
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cen"}, 64'(ram_cen_o), 64'd0);
    check({tag, "_wen"}, 64'(ram_wen_o), 64'd0);
    check({tag, "_addr"}, ram_addr_o, 64'd0);
    check({tag, "_wdata"}, ram_wdata_o, 64'd0);
    check({tag, "_mask_size"}, 64'({ram_wmask_o, ram_size_o}), 64'd0);
    check({tag, "_readys"}, 64'({if_ready_o, ls_ready_o}), 64'd0);
    check({tag, "_if_data"}, 64'(if_data_o), 64'd0);
    check({tag, "_ls_rdata"}, ls_rdata_o, 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'd0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    do_xact(1'b0, 1'b0, 64'h8000_0004, 64'd0, 8'd0, 3'd2,
            64'h1122_3344, 3);
    do_xact(1'b1, 1'b1, 64'h8000_1000, 64'hAA, 8'h0F, 3'd3,
            64'd0, 3);
    check("if_hold", 64'(if_data_o), 64'h1122_3344);
    check("err_clear", 64'(err_o), 64'd0);
    do_xact(1'b1, 1'b0, 64'h8000_2000, 64'd0, 8'd0, 3'd3,
            64'h1122_3344_5566_7788, 3);

    // stale ready through RESP and IDLE must not complete the next access
    mem_en = 1'b0;
    stale = 1'b1;
    if_req_i = 1'b1;
    if_addr_i = 64'h8000_0008;
    @(negedge clock);
    check("stale_idle_rdy", 64'(if_ready_o), 64'd0);
    @(negedge clock);
    check("stale_req_cen", 64'(ram_cen_o), 64'd1);
    stale = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("stale_wait", 64'({ram_cen_o, if_ready_o}), 64'd2);
    end
    mem_en = 1'b1;
    sb.push_back('{1'b0, 64'h5566_7788});
    wait_ready(1'b0, 2, 64'h8000_0008, 64'd0, 1'b0, 8'd0, 3'd2);
    if_req_i = 1'b0;

    // both requesters pending: LSU first after reset, then alternate
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    if_req_i = 1'b1;
    if_addr_i = 64'h8000_0000;
    ls_req_i = 1'b1;
    ls_wen_i = 1'b0;
    ls_addr_i = 64'h8000_3000;
    ls_size_i = 3'd3;
    sb.push_back('{1'b1, 64'h1122_3344_5566_7788});
    sb.push_back('{1'b0, 64'h5566_7788});
    sb.push_back('{1'b1, 64'h1122_3344_5566_7788});
    sb.push_back('{1'b0, 64'h5566_7788});
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("alt_drain", 64'(sb.size()), 64'd0);
    if_req_i = 1'b0;
    ls_req_i = 1'b0;

    // memory never answers: forced completion with zero data
    mem_en = 1'b0;
    do_xact(1'b0, 1'b0, 64'h8000_0004, 64'd0, 8'd0, 3'd2,
            64'd0, TO + 1);
    check("err_set", 64'(err_o), 64'd1);
    mem_en = 1'b1;
    do_xact(1'b1, 1'b0, 64'h8000_4000, 64'd0, 8'd0, 3'd3,
            64'h1122_3344_5566_7788, 3);
    check("err_sticky", 64'(err_o), 64'd1);

    // reset in the middle of REQ, request kept high
    @(negedge clock);
    mem_en = 1'b0;
    if_req_i = 1'b1;
    if_addr_i = 64'h8000_0004;
    repeat (3) @(negedge clock);
    check("mid_req_cen", 64'(ram_cen_o), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check_zero("mid_reset");
    reset = 1'b0;
    mem_en = 1'b1;
    sb.push_back('{1'b0, 64'h1122_3344});
    wait_ready(1'b0, 3, 64'h8000_0004, 64'd0, 1'b0, 8'd0, 3'd2);
    if_req_i = 1'b0;

    repeat (4) @(negedge clock);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_rw_arbiter.md
RAM_RW_ARBITER -- requirements
Module: ram_rw_arbiter

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clock.
REQ-002 Parameter: TIMEOUT, default 1024, REQ-state cycles before forced completion.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  in  1  clock
  reset  in  1  sync active-high reset
  if_req_i  in  1  IFU fetch request, held until if_ready_o
  if_addr_i  in  64  fetch byte address
  if_ready_o  out  1  one-cycle fetch completion pulse
  if_data_o  out  32  fetched instruction
  ls_req_i  in  1  LSU request, held until ls_ready_o
  ls_wen_i  in  1  1=store, 0=load
  ls_addr_i  in  64  LSU byte address
  ls_wdata_i  in  64  store data
  ls_wmask_i  in  8  store byte mask
  ls_size_i  in  3  access size
  ls_ready_o  out  1  one-cycle LSU completion pulse
  ls_rdata_o  out  64  load data
  ram_cen_o  out  1  memory enable
  ram_wen_o  out  1  memory write enable
  ram_addr_o  out  64  memory address
  ram_wdata_o  out  64  memory write data
  ram_wmask_o  out  8  memory byte mask
  ram_size_o  out  3  memory access size
  ram_ready_i  in  1  memory completion
  ram_data_i  in  64  memory read data
  err_o  out  1  sticky timeout flag

Function
REQ-004 FSM states: IDLE, REQ, RESP; all outputs registered.
REQ-005 IDLE: any request pending -> grant, latch granted requester's addr/wdata/wmask/size/wen into ram_* registers, go REQ.
REQ-006 Arbitration: LSU wins when only LSU pending or last grant was IFU; IFU wins when only IFU pending or last grant was LSU; last-grant register resets to IFU (so first simultaneous request goes to LSU).
REQ-007 IFU grant: ram_wen_o=0, ram_wmask_o=0, ram_size_o=3'd2, ram_addr_o=if_addr_i.
REQ-008 REQ: ram_cen_o=1, ram_* fields held constant; ram_ready_i=1 -> latch data, go RESP.
REQ-009 ram_ready_i SHALL be ignored in IDLE and RESP (stale-ready immunity).
REQ-010 RESP: exactly one of if_ready_o/ls_ready_o high one cycle, ram_cen_o=0; next state IDLE; requests ignored in RESP.
REQ-011 if_data_o = latched addr[2] ? ram_data_i[63:32] : ram_data_i[31:0]; ls_rdata_o = ram_data_i for loads, 0 for stores.
REQ-012 Data outputs SHALL hold last value until next RESP.
REQ-013 Latency with one-cycle memory: request seen in IDLE at cycle T -> ram_cen_o at T+1 -> ready pulse at T+3; minimum one IDLE cycle between grants.
REQ-014 Timeout: 10-bit-or-wider counter increments each REQ cycle, clears on entering REQ; reaching TIMEOUT-1 without ram_ready_i -> RESP with data 0, err_o set.
REQ-015 err_o SHALL remain 1 until reset.
REQ-016 Requests deasserted while in REQ SHALL not abort the transaction.

Reset
REQ-017 Reset (also mid-transaction) SHALL within one edge force IDLE, ram_cen_o=0, ram_wen_o=0, ram_addr_o=0, ram_wdata_o=0, ram_wmask_o=0, ram_size_o=0, if_ready_o=0, ls_ready_o=0, if_data_o=0, ls_rdata_o=0, err_o=0, timeout counter 0, last grant=IFU.

Verification
REQ-018 IFU only, if_addr_i=0x80000004, ram_data_i=0x11223344_55667788, one-cycle-ready memory -> if_ready_o pulse at T+3, if_data_o=0x11223344.
REQ-019 LSU store addr 0x80001000, wmask 0x0F, wdata 0xAA -> ram_wen_o=1, ram_wmask_o=0x0F for REQ cycles; ls_ready_o one pulse; ls_rdata_o=0.
REQ-020 Both pending continuously -> grants alternate LSU, IFU, LSU, IFU; never two ready pulses in one cycle.
REQ-021 Memory never returns ready, TIMEOUT=16 -> RESP after 16 REQ cycles, ready pulse with data 0, err_o=1 and held until reset.
REQ-022 Reset asserted during REQ -> next cycle all outputs zero, state IDLE; held IFU request granted normally afterwards.
REQ-023 Memory delivering stale ram_ready_i the cycle after RESP -> no extra completion, next transaction waits for fresh ready.
